// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: ALU opcodes, forward selects, control bundles.
// Latency: n/a (types and constants only).
// Backpressure: n/a; stall/flush semantics live in the stage modules.
package mips_pkg;

  // 3-bit ALU control codes produced by the decoder
  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_ANDN = 3'b100;
  localparam logic [2:0] ALU_ORN  = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  // Operand forward select; 2'b11 is reserved and behaves like FWD_RF
  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  // Control carried through the ID/EX register
  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regdst;
    logic [2:0] alucontrol;
  } ex_ctrl_t;

  // Control carried through the EX/MEM register
  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic memwrite;
  } mem_ctrl_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub/and/or/slt plus and-not/or-not, with zero and signed-overflow flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
module alu
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic [2:0]       alucontrol,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ovf
);

  logic [WIDTH-1:0] bb;
  logic [WIDTH-1:0] sum;
  logic             slt;

  // Shared adder: bit 2 of the code selects subtract (invert B, carry in 1)
  always_comb begin
    bb  = alucontrol[2] ? ~srcb : srcb;
    sum = srca + bb + {{(WIDTH-1){1'b0}}, alucontrol[2]};
    // Signed compare gives the sign of the true difference, so it stays right on overflow
    slt = ($signed(srca) < $signed(srcb));
  end

  // Result select; reserved and unknown codes yield 0
  always_comb begin
    result = '0;
    case (alucontrol)
      ALU_ADD,
      ALU_SUB:  result = sum;
      ALU_AND:  result = srca & srcb;
      ALU_OR:   result = srca | srcb;
      ALU_SLT:  result = {{(WIDTH-1){1'b0}}, slt};
      ALU_ANDN: result = srca & ~srcb;
      ALU_ORN:  result = srca | ~srcb;
      default:  result = '0;
    endcase
  end

  // Flags: overflow only meaningful for add/sub (operands agree in sign, sum disagrees)
  always_comb begin
    zero = (result == '0);
    ovf  = ((alucontrol == ALU_ADD) || (alucontrol == ALU_SUB)) &&
           (srca[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != srca[WIDTH-1]);
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, operand forwarding, ALU, EX/MEM register.
// Latency: 2 clk edges from ID capture to aluout_m (ID/EX, then EX/MEM).
// Backpressure: stall_e holds ID/EX, flush_e inserts a bubble (wins over stall); EX/MEM never stalls.
// Optional: define EX_OVERFLOW_DETECT_EN to flag add/sub signed overflow and suppress its writes.
module ex_stage
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_e,
  input  logic             flush_e,
  input  logic [WIDTH-1:0] rd1_d,
  input  logic [WIDTH-1:0] rd2_d,
  input  logic [WIDTH-1:0] signimm_d,
  input  logic [RADDR-1:0] rs_d,
  input  logic [RADDR-1:0] rt_d,
  input  logic [RADDR-1:0] rd_d,
  input  logic             regwrite_d,
  input  logic             memtoreg_d,
  input  logic             memwrite_d,
  input  logic             alusrc_d,
  input  logic             regdst_d,
  input  logic [2:0]       alucontrol_d,
  input  logic [1:0]       forwarda_e,
  input  logic [1:0]       forwardb_e,
  input  logic [WIDTH-1:0] result_w,
  output logic [RADDR-1:0] rs_e,
  output logic [RADDR-1:0] rt_e,
  output logic [RADDR-1:0] writereg_e,
  output logic             regwrite_e,
  output logic             memtoreg_e,
  output logic [WIDTH-1:0] aluout_m,
  output logic [WIDTH-1:0] writedata_m,
  output logic [RADDR-1:0] writereg_m,
  output logic             regwrite_m,
  output logic             memtoreg_m,
  output logic             memwrite_m,
  output logic             zero_m,
  output logic             ovf_m
);

`ifdef EX_OVERFLOW_DETECT_EN
  localparam bit OVF_DETECT = 1'b1;
`else
  localparam bit OVF_DETECT = 1'b0;
`endif

  // ID/EX state
  ex_ctrl_t         ctrl_e_q, ctrl_e_d;
  logic [WIDTH-1:0] rd1_e_q, rd1_e_d;
  logic [WIDTH-1:0] rd2_e_q, rd2_e_d;
  logic [WIDTH-1:0] signimm_e_q, signimm_e_d;
  logic [RADDR-1:0] rs_e_q, rs_e_d;
  logic [RADDR-1:0] rt_e_q, rt_e_d;
  logic [RADDR-1:0] rd_e_q, rd_e_d;

  // EX/MEM state
  mem_ctrl_t        ctrl_m_q, ctrl_m_d;
  logic [WIDTH-1:0] aluout_m_q, aluout_m_d;
  logic [WIDTH-1:0] writedata_m_q, writedata_m_d;
  logic [RADDR-1:0] writereg_m_q, writereg_m_d;
  logic             zero_m_q, zero_m_d;
  logic             ovf_m_q, ovf_m_d;

  // E-stage datapath
  logic [WIDTH-1:0] srca, srcb, wdata;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero, alu_ovf, ovf_hit;
  logic [RADDR-1:0] writereg;

  // ID/EX next state: flush beats stall beats load
  always_comb begin
    ctrl_e_d    = ctrl_e_q;
    rd1_e_d     = rd1_e_q;
    rd2_e_d     = rd2_e_q;
    signimm_e_d = signimm_e_q;
    rs_e_d      = rs_e_q;
    rt_e_d      = rt_e_q;
    rd_e_d      = rd_e_q;
    if (flush_e) begin
      ctrl_e_d    = '0;
      rd1_e_d     = '0;
      rd2_e_d     = '0;
      signimm_e_d = '0;
      rs_e_d      = '0;
      rt_e_d      = '0;
      rd_e_d      = '0;
    end else if (!stall_e) begin
      ctrl_e_d.regwrite   = regwrite_d;
      ctrl_e_d.memtoreg   = memtoreg_d;
      ctrl_e_d.memwrite   = memwrite_d;
      ctrl_e_d.alusrc     = alusrc_d;
      ctrl_e_d.regdst     = regdst_d;
      ctrl_e_d.alucontrol = alucontrol_d;
      rd1_e_d             = rd1_d;
      rd2_e_d             = rd2_d;
      signimm_e_d         = signimm_d;
      rs_e_d              = rs_d;
      rt_e_d              = rt_d;
      rd_e_d              = rd_d;
    end
  end

  // Operand forwarding from MEM (pre-edge aluout_m) and WB; reserved select reads the regfile value
  always_comb begin
    srca = rd1_e_q;
    case (forwarda_e)
      FWD_WB:  srca = result_w;
      FWD_MEM: srca = aluout_m_q;
      default: srca = rd1_e_q;
    endcase
    wdata = rd2_e_q;
    case (forwardb_e)
      FWD_WB:  wdata = result_w;
      FWD_MEM: wdata = aluout_m_q;
      default: wdata = rd2_e_q;
    endcase
    srcb     = ctrl_e_q.alusrc ? signimm_e_q : wdata;
    writereg = ctrl_e_q.regdst ? rd_e_q : rt_e_q;
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .srca       (srca),
    .srcb       (srcb),
    .alucontrol (ctrl_e_q.alucontrol),
    .result     (alu_result),
    .zero       (alu_zero),
    .ovf        (alu_ovf)
  );

  // EX/MEM next state: always captures; an overflowing add/sub loses its side effects when detection is built in
  always_comb begin
    ovf_hit                = OVF_DETECT && alu_ovf;
    ctrl_m_d.regwrite      = ctrl_e_q.regwrite && !ovf_hit;
    ctrl_m_d.memtoreg      = ctrl_e_q.memtoreg;
    ctrl_m_d.memwrite      = ctrl_e_q.memwrite && !ovf_hit;
    aluout_m_d             = alu_result;
    writedata_m_d          = wdata;
    writereg_m_d           = writereg;
    zero_m_d               = alu_zero;
    ovf_m_d                = ovf_hit;
  end

  // Pipeline registers; reset discards everything in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_e_q      <= '0;
      rd1_e_q       <= '0;
      rd2_e_q       <= '0;
      signimm_e_q   <= '0;
      rs_e_q        <= '0;
      rt_e_q        <= '0;
      rd_e_q        <= '0;
      ctrl_m_q      <= '0;
      aluout_m_q    <= '0;
      writedata_m_q <= '0;
      writereg_m_q  <= '0;
      zero_m_q      <= 1'b0;
      ovf_m_q       <= 1'b0;
    end else begin
      ctrl_e_q      <= ctrl_e_d;
      rd1_e_q       <= rd1_e_d;
      rd2_e_q       <= rd2_e_d;
      signimm_e_q   <= signimm_e_d;
      rs_e_q        <= rs_e_d;
      rt_e_q        <= rt_e_d;
      rd_e_q        <= rd_e_d;
      ctrl_m_q      <= ctrl_m_d;
      aluout_m_q    <= aluout_m_d;
      writedata_m_q <= writedata_m_d;
      writereg_m_q  <= writereg_m_d;
      zero_m_q      <= zero_m_d;
      ovf_m_q       <= ovf_m_d;
    end
  end

  // Output mapping
  always_comb begin
    rs_e        = rs_e_q;
    rt_e        = rt_e_q;
    writereg_e  = writereg;
    regwrite_e  = ctrl_e_q.regwrite;
    memtoreg_e  = ctrl_e_q.memtoreg;
    aluout_m    = aluout_m_q;
    writedata_m = writedata_m_q;
    writereg_m  = writereg_m_q;
    regwrite_m  = ctrl_m_q.regwrite;
    memtoreg_m  = ctrl_m_q.memtoreg;
    memwrite_m  = ctrl_m_q.memwrite;
    zero_m      = zero_m_q;
    ovf_m       = ovf_m_q;
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset, ALU ops, forwarding, stall/flush, overflow option.
// Latency: results checked two edges after the ID capture edge.
// Backpressure: stall_e/flush_e driven directly from the stimulus.
module tb_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_e, flush_e;
  logic [31:0] rd1_d, rd2_d, signimm_d, result_w;
  logic [4:0]  rs_d, rt_d, rd_d;
  logic        regwrite_d, memtoreg_d, memwrite_d, alusrc_d, regdst_d;
  logic [2:0]  alucontrol_d;
  logic [1:0]  forwarda_e, forwardb_e;
  logic [4:0]  rs_e, rt_e, writereg_e, writereg_m;
  logic        regwrite_e, memtoreg_e;
  logic [31:0] aluout_m, writedata_m;
  logic        regwrite_m, memtoreg_m, memwrite_m, zero_m, ovf_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage #(.WIDTH(32), .RADDR(5)) dut (
    .clk(clk), .reset(reset), .stall_e(stall_e), .flush_e(flush_e),
    .rd1_d(rd1_d), .rd2_d(rd2_d), .signimm_d(signimm_d),
    .rs_d(rs_d), .rt_d(rt_d), .rd_d(rd_d),
    .regwrite_d(regwrite_d), .memtoreg_d(memtoreg_d), .memwrite_d(memwrite_d),
    .alusrc_d(alusrc_d), .regdst_d(regdst_d), .alucontrol_d(alucontrol_d),
    .forwarda_e(forwarda_e), .forwardb_e(forwardb_e), .result_w(result_w),
    .rs_e(rs_e), .rt_e(rt_e), .writereg_e(writereg_e),
    .regwrite_e(regwrite_e), .memtoreg_e(memtoreg_e),
    .aluout_m(aluout_m), .writedata_m(writedata_m), .writereg_m(writereg_m),
    .regwrite_m(regwrite_m), .memtoreg_m(memtoreg_m), .memwrite_m(memwrite_m),
    .zero_m(zero_m), .ovf_m(ovf_m)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                       input logic asrc, input logic [2:0] aluc, input logic rw, input logic mw,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
    rd1_d        = a;
    rd2_d        = b;
    signimm_d    = imm;
    alusrc_d     = asrc;
    alucontrol_d = aluc;
    regwrite_d   = rw;
    memwrite_d   = mw;
    memtoreg_d   = 1'b0;
    regdst_d     = 1'b1;
    rs_d         = rs;
    rt_d         = rt;
    rd_d         = rd;
  endtask

  task automatic bubble();
    issue(32'd0, 32'd0, 32'd0, 1'b0, 3'b000, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  // ALU vectors: operand A, operand B, immediate, alusrc, code, expected result
  logic [31:0] va [12] = '{32'd5, 32'd5, 32'd3, 32'h0000F0F0, 32'h0000F0F0, 32'hFFFFFFFF,
                           32'h7FFFFFFF, 32'h0000000F, 32'h000000FF, 32'h00000000, 32'd5, 32'hFFFFFFFF};
  logic [31:0] vb [12] = '{32'd3, 32'd3, 32'd3, 32'h0000FF00, 32'h0000FF00, 32'h00000001,
                           32'h80000000, 32'h00000000, 32'h0000000F, 32'hFFFFFFF0, 32'd3, 32'hFFFFFFFF};
  logic [31:0] vi [12] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0,
                           32'd0, 32'h00000010, 32'd0, 32'd0, 32'd0, 32'd0};
  logic        vs [12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [2:0]  vc [12] = '{3'b010, 3'b110, 3'b110, 3'b000, 3'b001, 3'b111,
                           3'b111, 3'b111, 3'b100, 3'b101, 3'b011, 3'b010};
  logic [31:0] ve [12] = '{32'd8, 32'd2, 32'd0, 32'h0000F000, 32'h0000FFF0, 32'd1,
                           32'd0, 32'd1, 32'h000000F0, 32'h0000000F, 32'd0, 32'hFFFFFFFE};

  initial begin
    reset      = 1'b1;
    stall_e    = 1'b0;
    flush_e    = 1'b0;
    forwarda_e = 2'b00;
    forwardb_e = 2'b00;
    result_w   = 32'd0;
    issue(32'd5, 32'd3, 32'd0, 1'b0, 3'b010, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3);
    step();
    step();

    // Reset state with live inputs
    chk("rst_aluout_m", aluout_m, 32'd0);
    chk("rst_regwrite_m", {31'd0, regwrite_m}, 32'd0);
    chk("rst_memwrite_m", {31'd0, memwrite_m}, 32'd0);
    chk("rst_zero_m", {31'd0, zero_m}, 32'd0);
    chk("rst_rs_e", {27'd0, rs_e}, 32'd0);
    chk("rst_regwrite_e", {31'd0, regwrite_e}, 32'd0);
    chk("rst_ovf_m", {31'd0, ovf_m}, 32'd0);

    bubble();
    #3 reset = 1'b0;
    step();

    // ALU table, pipelined: result of vector i-1 is in MEM after vector i is captured
    for (int i = 0; i < 12; i++) begin
      issue(va[i], vb[i], vi[i], vs[i], vc[i], 1'b1, 1'b0, 5'd1, 5'd2, 5'd3);
      step();
      if (i > 0) begin
        chk($sformatf("alu%0d_out", i - 1), aluout_m, ve[i-1]);
        chk($sformatf("alu%0d_zero", i - 1), {31'd0, zero_m}, {31'd0, (ve[i-1] == 32'd0)});
        chk($sformatf("alu%0d_wdata", i - 1), writedata_m, vb[i-1]);
        chk($sformatf("alu%0d_rw", i - 1), {31'd0, regwrite_m}, 32'd1);
        chk($sformatf("alu%0d_wreg", i - 1), {27'd0, writereg_m}, 32'd3);
      end
    end
    bubble();
    step();
    chk("alu11_out", aluout_m, ve[11]);
    chk("alu11_zero", {31'd0, zero_m}, 32'd0);

    // Signed overflow on add
    issue(32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 3'b010, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3);
    step();
    bubble();
    step();
    chk("ovf_aluout_m", aluout_m, 32'h80000000);
`ifdef EX_OVERFLOW_DETECT_EN
    chk("ovf_flag", {31'd0, ovf_m}, 32'd1);
    chk("ovf_regwrite_m", {31'd0, regwrite_m}, 32'd0);
    chk("ovf_memwrite_m", {31'd0, memwrite_m}, 32'd0);
`else
    chk("ovf_flag", {31'd0, ovf_m}, 32'd0);
    chk("ovf_regwrite_m", {31'd0, regwrite_m}, 32'd1);
    chk("ovf_memwrite_m", {31'd0, memwrite_m}, 32'd1);
`endif

    // Forwarding: MEM into A, WB into B
    issue(32'h10, 32'h10, 32'd0, 1'b0, 3'b010, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3);
    step();
    issue(32'd0, 32'd0, 32'd4, 1'b1, 3'b010, 1'b1, 1'b0, 5'd4, 5'd5, 5'd6);
    step();
    chk("fwd_src_out", aluout_m, 32'h20);
    forwarda_e = 2'b10;
    forwardb_e = 2'b01;
    result_w   = 32'd7;
    issue(32'd1, 32'h55, 32'd0, 1'b0, 3'b010, 1'b1, 1'b0, 5'd1, 5'd2, 5'd3);
    step();
    chk("fwd_mem_a", aluout_m, 32'h24);
    chk("fwd_wb_b", writedata_m, 32'd7);
    // WB into A, reserved select on B reads the register file value
    forwarda_e = 2'b01;
    forwardb_e = 2'b11;
    bubble();
    step();
    chk("fwd_wb_a", aluout_m, 32'h5C);
    chk("fwd_rsvd_b", writedata_m, 32'h55);
    forwarda_e = 2'b00;
    forwardb_e = 2'b00;

    // Stall holds ID/EX for two cycles
    issue(32'd9, 32'd1, 32'd0, 1'b0, 3'b110, 1'b1, 1'b0, 5'd7, 5'd8, 5'd9);
    step();
    chk("stl_rs_e", {27'd0, rs_e}, 32'd7);
    chk("stl_writereg_e", {27'd0, writereg_e}, 32'd9);
    chk("stl_regwrite_e", {31'd0, regwrite_e}, 32'd1);
    issue(32'd100, 32'd50, 32'd0, 1'b0, 3'b010, 1'b1, 1'b1, 5'h1F, 5'h1E, 5'h1D);
    memtoreg_d = 1'b1;
    stall_e    = 1'b1;
    step();
    chk("stl1_rs_e", {27'd0, rs_e}, 32'd7);
    chk("stl1_rt_e", {27'd0, rt_e}, 32'd8);
    chk("stl1_aluout_m", aluout_m, 32'd8);
    step();
    chk("stl2_rs_e", {27'd0, rs_e}, 32'd7);
    chk("stl2_rt_e", {27'd0, rt_e}, 32'd8);
    chk("stl2_aluout_m", aluout_m, 32'd8);
    stall_e = 1'b0;
    step();
    chk("ld_rs_e", {27'd0, rs_e}, 32'h1F);
    chk("ld_memtoreg_e", {31'd0, memtoreg_e}, 32'd1);
    chk("ld_writereg_e", {27'd0, writereg_e}, 32'h1D);

    // Flush inserts a bubble into E while MEM still receives the prior instruction
    issue(32'd3, 32'd3, 32'd0, 1'b0, 3'b010, 1'b1, 1'b1, 5'd2, 5'd3, 5'd4);
    flush_e = 1'b1;
    step();
    chk("fl_regwrite_e", {31'd0, regwrite_e}, 32'd0);
    chk("fl_memtoreg_e", {31'd0, memtoreg_e}, 32'd0);
    chk("fl_rs_e", {27'd0, rs_e}, 32'd0);
    chk("fl_writereg_e", {27'd0, writereg_e}, 32'd0);
    chk("fl_prev_out", aluout_m, 32'd150);
    chk("fl_prev_memwrite_m", {31'd0, memwrite_m}, 32'd1);
    chk("fl_prev_memtoreg_m", {31'd0, memtoreg_m}, 32'd1);
    // Flush together with stall still gives a bubble
    stall_e = 1'b1;
    step();
    chk("flst_regwrite_e", {31'd0, regwrite_e}, 32'd0);
    chk("flst_rs_e", {27'd0, rs_e}, 32'd0);
    chk("fl_regwrite_m", {31'd0, regwrite_m}, 32'd0);
    chk("fl_memwrite_m", {31'd0, memwrite_m}, 32'd0);
    flush_e = 1'b0;
    stall_e = 1'b0;
    issue(32'd2, 32'd1, 32'd0, 1'b0, 3'b110, 1'b1, 1'b0, 5'd3, 5'd4, 5'd5);
    regdst_d = 1'b0;
    step();
    chk("rt_dst_writereg_e", {27'd0, writereg_e}, 32'd4);
    chk("flst_regwrite_m", {31'd0, regwrite_m}, 32'd0);
    chk("flst_memwrite_m", {31'd0, memwrite_m}, 32'd0);

    // Asynchronous reset mid-stream
    issue(32'd5, 32'd3, 32'd0, 1'b0, 3'b010, 1'b1, 1'b1, 5'd1, 5'd2, 5'd3);
    step();
    chk("pre_rst_out", aluout_m, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_aluout_m", aluout_m, 32'd0);
    chk("arst_regwrite_m", {31'd0, regwrite_m}, 32'd0);
    chk("arst_writereg_m", {27'd0, writereg_m}, 32'd0);
    chk("arst_writedata_m", writedata_m, 32'd0);
    chk("arst_rs_e", {27'd0, rs_e}, 32'd0);
    chk("arst_regwrite_e", {31'd0, regwrite_e}, 32'd0);
    step();
    #2 reset = 1'b0;
    step();
    chk("post_rst_out", aluout_m, 32'd0);
    chk("post_rst_regwrite_m", {31'd0, regwrite_m}, 32'd0);
    step();
    chk("post_rst_first", aluout_m, 32'd8);
    chk("post_rst_first_rw", {31'd0, regwrite_m}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
